hb_target_lite: RTL and testbench

- Synthesizable HyperBus target (HyperRAM-like responder) that sits on the device end of the bus driven by the wb_hyperram controller.
- Used for on-chip loopback and bring-up: the controller's io pins are routed to this block instead of an external HyperRAM.
- Runs entirely on the Wishbone clock and oversamples the HyperBus CK, CS#, RWDS and DQ.
- Backs a small word-addressed register-file memory plus a read-only ID register.

---
 rtl/hb_target_lite.sv | 227 ++++++++++++++++++++++
 tb/tb_hb_target_lite.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hb_target_lite.sv
// HyperBus target for loopback and bring-up: an oversampled CK/CS#/RWDS/DQ front end, a word memory and a read-only ID register.
// Optional build macro HB_TARGET_2X_LATENCY_EN: RWDS is driven high during CA and the initial latency is doubled.
module hb_target_lite #(
  parameter int          ADDR_W     = 6,
  parameter int          LAT_CYCLES = 6,
  parameter logic [15:0] ID_VALUE   = 16'h0C81
) (
  input  logic       wb_clk_i,
  input  logic       wb_rst_i,
  input  logic       hb_rstn_i,
  input  logic       hb_csn_i,
  input  logic       hb_clk_i,
  input  logic       hb_rwds_i,
  output logic       hb_rwds_o,
  output logic       hb_rwds_oen,
  input  logic [7:0] hb_dq_i,
  output logic [7:0] hb_dq_o,
  output logic [7:0] hb_dq_oen,
  output logic [2:0] dbg_state
);

  // Bus protocol: when CS# is low, each CK edge (rise or fall) carries one
  // byte on DQ. The master qualifies write bytes with RWDS (high = masked).
  // On reads the target drives DQ and toggles RWDS one cycle after each
  // byte appears, so RWDS changes always mark a stable byte.

`ifdef HB_TARGET_2X_LATENCY_EN
  localparam int   LAT_EDGES = 4 * LAT_CYCLES;
  localparam logic CA_RWDS   = 1'b1;
`else
  localparam int   LAT_EDGES = 2 * LAT_CYCLES;
  localparam logic CA_RWDS   = 1'b0;
`endif

  localparam logic [7:0]        LAT_LAST = 8'(LAT_EDGES - 1);
  localparam logic [ADDR_W-1:0] LOW_MASK = ADDR_W'(15);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CA    = 3'd1,
    S_LAT   = 3'd2,
    S_WDATA = 3'd3,
    S_RDATA = 3'd4,
    S_REGW  = 3'd5
  } state_t;

  state_t state, state_n;

  logic [1:0] csn_sr, ck_sr, rwds_sr, rstn_sr;
  logic [7:0] dq_sr0, dq_sr1;
  logic       ck_prev;

  logic       csn_s, ck_s, rwds_s, rstn_s, rst_all, ck_edge;
  logic [7:0] dq_s;

  logic [39:0]       ca;
  logic [47:0]       ca_next;
  logic [ADDR_W-1:0] ca_addr;
  logic [7:0]        cnt;
  logic              is_rd, is_reg, is_lin;
  logic [ADDR_W-1:0] addr, addr_plus, addr_inc;
  logic              phase;
  logic [7:0]        hi_byte;
  logic              hi_mask;
  logic [7:0]        dq_q;
  logic              rwds_q, tog_pend;
  logic [15:0]       rd_word;
  logic              wr_en;
  logic              unused_ca;

  logic [15:0] mem [0:(1<<ADDR_W)-1];

  // Two-flop synchronizers; every HyperBus input shares the same depth so
  // DQ/RWDS stay aligned with the CK edge that qualifies them.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      csn_sr  <= 2'b11;
      ck_sr   <= 2'b00;
      rwds_sr <= 2'b00;
      rstn_sr <= 2'b00;
      dq_sr0  <= 8'h00;
      dq_sr1  <= 8'h00;
      ck_prev <= 1'b0;
    end else begin
      csn_sr  <= {csn_sr[0], hb_csn_i};
      ck_sr   <= {ck_sr[0], hb_clk_i};
      rwds_sr <= {rwds_sr[0], hb_rwds_i};
      rstn_sr <= {rstn_sr[0], hb_rstn_i};
      dq_sr0  <= hb_dq_i;
      dq_sr1  <= dq_sr0;
      ck_prev <= ck_sr[1];
    end
  end

  assign csn_s   = csn_sr[1];
  assign ck_s    = ck_sr[1];
  assign rwds_s  = rwds_sr[1];
  assign rstn_s  = rstn_sr[1];
  assign dq_s    = dq_sr1;
  assign rst_all = wb_rst_i | ~rstn_s;
  assign ck_edge = ck_s ^ ck_prev;

  assign ca_next   = {ca, dq_s};
  assign ca_addr   = {ca_next[ADDR_W+12:16], ca_next[2:0]};
  assign unused_ca = ^{ca_next[44:ADDR_W+13], ca_next[15:3]};

  assign addr_plus = addr + ADDR_W'(1);
  assign addr_inc  = is_lin ? addr_plus : ((addr & ~LOW_MASK) | (addr_plus & LOW_MASK));
  assign rd_word   = is_reg ? ID_VALUE : mem[addr];

  always_ff @(posedge wb_clk_i) begin
    if (rst_all) state <= S_IDLE;
    else         state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (csn_s) begin
      state_n = S_IDLE;
    end else begin
      case (state)
        S_IDLE: state_n = S_CA;
        S_CA: begin
          if (ck_edge && cnt == 8'd5)
            state_n = (!ca_next[47] && ca_next[46]) ? S_REGW : S_LAT;
        end
        S_LAT: begin
          if (ck_edge && cnt == LAT_LAST)
            state_n = is_rd ? S_RDATA : S_WDATA;
        end
        S_WDATA, S_RDATA, S_REGW: state_n = state;
        default: state_n = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (rst_all) begin
      ca       <= '0;
      cnt      <= 8'd0;
      is_rd    <= 1'b0;
      is_reg   <= 1'b0;
      is_lin   <= 1'b0;
      addr     <= '0;
      phase    <= 1'b0;
      hi_byte  <= 8'h00;
      hi_mask  <= 1'b0;
      dq_q     <= 8'h00;
      rwds_q   <= 1'b0;
      tog_pend <= 1'b0;
    end else begin
      tog_pend <= 1'b0;
      // RWDS trails the byte by one cycle so it marks data already stable.
      if (tog_pend) rwds_q <= ~rwds_q;
      case (state)
        S_IDLE: begin
          cnt    <= 8'd0;
          phase  <= 1'b0;
          rwds_q <= 1'b0;
          dq_q   <= 8'h00;
        end
        S_CA: begin
          if (ck_edge) begin
            ca  <= ca_next[39:0];
            cnt <= cnt + 8'd1;
            if (cnt == 8'd5) begin
              is_rd  <= ca_next[47];
              is_reg <= ca_next[46];
              is_lin <= ca_next[45];
              addr   <= ca_addr;
              cnt    <= 8'd0;
            end
          end
        end
        S_LAT: begin
          if (ck_edge) cnt <= (cnt == LAT_LAST) ? 8'd0 : cnt + 8'd1;
        end
        S_WDATA: begin
          if (ck_edge && !csn_s) begin
            if (!phase) begin
              hi_byte <= dq_s;
              hi_mask <= rwds_s;
            end else begin
              addr <= addr_inc;
            end
            phase <= ~phase;
          end
        end
        S_RDATA: begin
          if (ck_edge && !csn_s) begin
            dq_q     <= phase ? rd_word[7:0] : rd_word[15:8];
            tog_pend <= 1'b1;
            phase    <= ~phase;
            if (phase) addr <= addr_inc;
          end
        end
        S_REGW: begin
          // Two data edges are swallowed, then the block simply holds.
          if (ck_edge && cnt != 8'd2) cnt <= cnt + 8'd1;
        end
        default: cnt <= 8'd0;
      endcase
    end
  end

  // A word commits only on its second byte, so an aborted half word is lost.
  assign wr_en = (state == S_WDATA) && ck_edge && phase && !csn_s && !rst_all;

  always_ff @(posedge wb_clk_i) begin
    if (wr_en) begin
      if (!hi_mask) mem[addr][15:8] <= hi_byte;
      if (!rwds_s)  mem[addr][7:0]  <= dq_s;
    end
  end

  always_comb begin
    hb_dq_oen   = (state == S_RDATA) ? 8'h00 : 8'hFF;
    hb_rwds_oen = !((state == S_CA) || (state == S_RDATA));
    hb_rwds_o   = 1'b0;
    if (state == S_CA)         hb_rwds_o = CA_RWDS;
    else if (state == S_RDATA) hb_rwds_o = rwds_q;
  end

  assign hb_dq_o   = dq_q;
  assign dbg_state = state;

endmodule

// File: tb/tb_hb_target_lite.sv
// Self-checking bench for hb_target_lite: a HyperBus master driver, a memory model and a read-byte scoreboard.
module tb_hb_target_lite;

`ifdef HB_TARGET_2X_LATENCY_EN
  localparam int   LAT_EDGES = 24;
  localparam logic CA_RWDS   = 1'b1;
`else
  localparam int   LAT_EDGES = 12;
  localparam logic CA_RWDS   = 1'b0;
`endif

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_LAT  = 3'd2;
  localparam logic [2:0] ST_REGW = 3'd5;

  logic       wb_clk_i = 1'b0;
  logic       wb_rst_i;
  logic       hb_rstn_i;
  logic       hb_csn_i;
  logic       hb_clk_i;
  logic       hb_rwds_i;
  logic       hb_rwds_o;
  logic       hb_rwds_oen;
  logic [7:0] hb_dq_i;
  logic [7:0] hb_dq_o;
  logic [7:0] hb_dq_oen;
  logic [2:0] dbg_state;

  int checks = 0;
  int errors = 0;

  logic [7:0]  exp_q[$];
  logic [15:0] mem_m[64];
  int          tog_total;
  int          tog_cnt;
  logic        mon_rwds;

  hb_target_lite dut (
    .wb_clk_i   (wb_clk_i),
    .wb_rst_i   (wb_rst_i),
    .hb_rstn_i  (hb_rstn_i),
    .hb_csn_i   (hb_csn_i),
    .hb_clk_i   (hb_clk_i),
    .hb_rwds_i  (hb_rwds_i),
    .hb_rwds_o  (hb_rwds_o),
    .hb_rwds_oen(hb_rwds_oen),
    .hb_dq_i    (hb_dq_i),
    .hb_dq_o    (hb_dq_o),
    .hb_dq_oen  (hb_dq_oen),
    .dbg_state  (dbg_state)
  );

  // Clock and reset.
  always #5 wb_clk_i = ~wb_clk_i;

  initial begin
    #500000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  // Scoreboard: every RWDS change while the target drives the bus marks one byte.
  always @(negedge wb_clk_i) begin
    if (hb_dq_oen == 8'h00 && !hb_rwds_oen) begin
      if (hb_rwds_o != mon_rwds) begin
        if (tog_cnt == 0) chk_eq("rwds_first", {31'd0, hb_rwds_o}, 32'd1);
        if (exp_q.size() != 0) chk_eq("rd_byte", {24'd0, hb_dq_o}, {24'd0, exp_q.pop_front()});
        tog_cnt++;
        tog_total++;
      end
      mon_rwds = hb_rwds_o;
    end else begin
      mon_rwds = 1'b0;
      tog_cnt  = 0;
    end
  end

  function automatic logic [47:0] make_ca(input logic rd, input logic rg, input logic lin,
                                          input logic [5:0] a);
    logic [47:0] c;
    c        = '0;
    c[47]    = rd;
    c[46]    = rg;
    c[45]    = lin;
    c[18:16] = a[5:3];
    c[2:0]   = a[2:0];
    return c;
  endfunction

  // Driver tasks: DQ/RWDS settle two cycles before CK flips, hold three after.
  task automatic ck_edge(input logic [7:0] d, input logic rw);
    hb_dq_i   = d;
    hb_rwds_i = rw;
    repeat (2) @(negedge wb_clk_i);
    hb_clk_i = ~hb_clk_i;
    repeat (3) @(negedge wb_clk_i);
  endtask

  task automatic start_txn(input logic [47:0] ca, input logic [2:0] exp_state);
    hb_csn_i = 1'b0;
    repeat (3) @(negedge wb_clk_i);
    chk_eq("ca_rwds_oen", {31'd0, hb_rwds_oen}, 32'd0);
    chk_eq("ca_rwds_lvl", {31'd0, hb_rwds_o}, {31'd0, CA_RWDS});
    for (int i = 5; i >= 0; i--) ck_edge(ca[i*8 +: 8], 1'b0);
    chk_eq("post_ca_state", {29'd0, dbg_state}, {29'd0, exp_state});
  endtask

  task automatic lat_wait();
    for (int i = 0; i < LAT_EDGES; i++) ck_edge(8'h00, 1'b0);
  endtask

  task automatic end_txn();
    repeat (3) @(negedge wb_clk_i);
    hb_csn_i = 1'b1;
    repeat (4) @(negedge wb_clk_i);
  endtask

  task automatic write_burst(input int a, input int n, input logic [15:0] w0,
                             input logic [15:0] w1, input logic [15:0] w2);
    logic [15:0] w;
    start_txn(make_ca(1'b0, 1'b0, 1'b1, 6'(a)), ST_LAT);
    lat_wait();
    for (int i = 0; i < n; i++) begin
      w = (i == 0) ? w0 : ((i == 1) ? w1 : w2);
      ck_edge(w[15:8], 1'b0);
      ck_edge(w[7:0], 1'b0);
      mem_m[(a + i) % 64] = w;
    end
    end_txn();
  endtask

  task automatic read_burst(input int a, input logic lin, input logic rg, input int n);
    int          ad;
    logic [15:0] w;
    for (int i = 0; i < n; i++) begin
      ad = lin ? ((a + i) % 64) : ((a & ~15) | ((a + i) & 15));
      w  = rg ? 16'h0C81 : mem_m[ad];
      exp_q.push_back(w[15:8]);
      exp_q.push_back(w[7:0]);
    end
    tog_total = 0;
    start_txn(make_ca(1'b1, rg, lin, 6'(a)), ST_LAT);
    lat_wait();
    for (int i = 0; i < 2 * n; i++) ck_edge(8'h00, 1'b0);
    end_txn();
    chk_eq("rd_toggles", 32'(tog_total), 32'(2 * n));
    chk_eq("rd_drain", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    logic [15:0] r0, r1;
    int          ra;
    wb_rst_i  = 1'b1;
    hb_rstn_i = 1'b1;
    hb_csn_i  = 1'b1;
    hb_clk_i  = 1'b0;
    hb_rwds_i = 1'b0;
    hb_dq_i   = 8'h00;
    mon_rwds  = 1'b0;
    tog_cnt   = 0;
    tog_total = 0;
    repeat (2) @(negedge wb_clk_i);
    chk_eq("rst_dq_oen", {24'd0, hb_dq_oen}, 32'hFF);
    chk_eq("rst_rwds_oen", {31'd0, hb_rwds_oen}, 32'd1);
    chk_eq("rst_dq_o", {24'd0, hb_dq_o}, 32'd0);
    chk_eq("rst_rwds_o", {31'd0, hb_rwds_o}, 32'd0);
    chk_eq("rst_state", {29'd0, dbg_state}, {29'd0, ST_IDLE});
    wb_rst_i = 1'b0;
    repeat (4) @(negedge wb_clk_i);

    // Linear write then read back: A5 5A 12 34.
    write_burst(2, 2, 16'hA55A, 16'h1234, 16'h0000);
    read_burst(2, 1'b1, 1'b0, 2);

    // Byte mask: low byte masked, preloaded word stays 00 there.
    write_burst(5, 1, 16'h0000, 16'h0000, 16'h0000);
    start_txn(make_ca(1'b0, 1'b0, 1'b1, 6'd5), ST_LAT);
    lat_wait();
    ck_edge(8'hFF, 1'b0);
    ck_edge(8'hFF, 1'b1);
    end_txn();
    mem_m[5] = 16'hFF00;
    read_burst(5, 1'b1, 1'b0, 1);

    // Wrap boundaries: 63 -> 0 on a linear burst, 15 -> 0 inside a 16-word group.
    write_burst(63, 3, 16'hC3C3, 16'h1111, 16'hBEEF);
    write_burst(15, 1, 16'h5AF0, 16'h0000, 16'h0000);
    read_burst(15, 1'b0, 1'b0, 2);
    read_burst(63, 1'b1, 1'b0, 2);

    // Register space: ID on reads, zero-latency writes that leave memory alone.
    read_burst(0, 1'b0, 1'b1, 2);
    start_txn(make_ca(1'b0, 1'b1, 1'b1, 6'd0), ST_REGW);
    ck_edge(8'hDE, 1'b0);
    ck_edge(8'hAD, 1'b0);
    chk_eq("regw_hold", {29'd0, dbg_state}, {29'd0, ST_REGW});
    end_txn();
    read_burst(0, 1'b1, 1'b0, 1);

    // Abort after 1.5 words: word 0 commits, word 1 keeps its old value.
    start_txn(make_ca(1'b0, 1'b0, 1'b1, 6'd0), ST_LAT);
    lat_wait();
    ck_edge(8'h77, 1'b0);
    ck_edge(8'h88, 1'b0);
    ck_edge(8'h99, 1'b0);
    hb_csn_i = 1'b1;
    repeat (3) @(negedge wb_clk_i);
    chk_eq("abort_dq_oen", {24'd0, hb_dq_oen}, 32'hFF);
    chk_eq("abort_rwds_oen", {31'd0, hb_rwds_oen}, 32'd1);
    chk_eq("abort_state", {29'd0, dbg_state}, {29'd0, ST_IDLE});
    mem_m[0] = 16'h7788;
    repeat (3) @(negedge wb_clk_i);
    read_burst(0, 1'b1, 1'b0, 2);

    // Aborted read: the driven bus must be released within three cycles.
    exp_q.push_back(mem_m[2][15:8]);
    exp_q.push_back(mem_m[2][7:0]);
    exp_q.push_back(mem_m[3][15:8]);
    start_txn(make_ca(1'b1, 1'b0, 1'b1, 6'd2), ST_LAT);
    lat_wait();
    for (int i = 0; i < 3; i++) ck_edge(8'h00, 1'b0);
    hb_csn_i = 1'b1;
    repeat (3) @(negedge wb_clk_i);
    chk_eq("rd_abort_dq_oen", {24'd0, hb_dq_oen}, 32'hFF);
    chk_eq("rd_abort_rwds_oen", {31'd0, hb_rwds_oen}, 32'd1);
    chk_eq("rd_abort_drain", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    repeat (3) @(negedge wb_clk_i);

    // Random linear bursts at random addresses.
    for (int k = 0; k < 4; k++) begin
      ra = $urandom_range(0, 63);
      r0 = 16'($urandom_range(0, 65535));
      r1 = 16'($urandom_range(0, 65535));
      write_burst(ra, 2, r0, r1, 16'h0000);
      read_burst(ra, 1'b1, 1'b0, 2);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
